register_file_2r1w: RTL
=======================

Name: register_file_2r1w

Overview:
- Parametrised successor to the team's single-port register file: one write port with byte enables and two independent registered read ports.
- Hardware clear sequencer zeroes every entry after reset or on request. No software init loop is needed.
- Sits in the datapath as an architectural register bank or configuration store, feeding two consumers per cycle.

Parameters:
- ADDR_WIDTH, 5: width of every address port.
- DATA_WIDTH, 32: word width. Must be a multiple of 8.
- DEPTH, 32: number of entries, 1..2^ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- init_req  input  1  pulse in IDLE: start a full clear sequence.
- busy  output  1  high while reset is asserted or a clear is in progress.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- wr_be  input  DATA_WIDTH/8  byte enables; bit i covers byte i.
- rd0_en  input  1  port 0 read request.
- rd0_addr  input  ADDR_WIDTH  port 0 address.
- rd0_data  output  DATA_WIDTH  port 0 registered read data.
- rd0_valid  output  1  port 0 data valid strobe.
- rd1_en  input  1  port 1 read request.
- rd1_addr  input  ADDR_WIDTH  port 1 address.
- rd1_data  output  DATA_WIDTH  port 1 registered read data.
- rd1_valid  output  1  port 1 data valid strobe.

Behaviour:
- Reset: asynchronous and active-high.
  - rd0_data=0, rd1_data=0, rd0_valid=0, rd1_valid=0, busy=1.
  - FSM goes to CLEAR and the clear counter to 0. Memory contents are not touched asynchronously.
- FSM states: CLEAR and IDLE.
  - CLEAR: each cycle writes 0 to entry[clr_cnt], then clr_cnt++. After writing entry DEPTH-1, next state is IDLE and busy falls.
  - A clear therefore takes exactly DEPTH cycles after rst deasserts.
  - IDLE: init_req=1 sets clr_cnt=0 and moves to CLEAR; busy rises the next cycle.
- While busy:
  - wr_en, rd0_en and rd1_en are ignored.
  - rdX_valid stays 0 and rdX_data holds its value.
  - init_req is ignored while in CLEAR.
- Reset asserted mid-clear: the sequence restarts from entry 0 after rst releases.
- Write (IDLE, wr_en=1, wr_addr<DEPTH): byte i of entry[wr_addr] is updated only where wr_be[i]=1. wr_be=0 is a legal no-op.
- Read latency is 1 cycle. A read accepted at edge N (IDLE, rdX_en=1) gives:
  - rdX_data = entry[rdX_addr] and rdX_valid=1 after edge N.
  - rdX_valid is a single-cycle pulse per accepted read.
  - Without a read, rdX_data holds its last value and rdX_valid=0.
- Both ports may read the same or different addresses in the same cycle; there are no conflicts.
- Out-of-range address (addr >= DEPTH):
  - The write is dropped.
  - The read returns 0 with rdX_valid=1.
- Same-cycle write and read to the same address: governed by WRITE_BYPASS_EN (below). Other addresses are unaffected.
- init_req and wr_en in the same IDLE cycle: the write is performed, then the clear starts and overwrites it.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: a read of the address being written in the same cycle returns the merged new word (wr_data bytes where wr_be=1, old bytes elsewhere). This is write-first behaviour and applies to each port independently.
- Undefined: the read returns the pre-write contents (read-first). The new value is visible from the next read onward.

Test Plan:
- Reset release, DEPTH=32: busy=1 for exactly 32 cycles after rst falls. Then read all 32 entries on both ports -> every rdX_data=0, rdX_valid=1 one cycle after each request.
- Write 0xDEADBEEF to addr 3 with wr_be=4'b1111, then write 0x000000AA with wr_be=4'b0001 to addr 3 -> a subsequent rd0 of addr 3 gives 0xDEADBEAA.
- Write 0x11111111 to addr 5 and 0x22222222 to addr 9. Next cycle read rd0=5 and rd1=9, then rd0=rd1=9 -> 0x11111111/0x22222222, then 0x22222222 on both ports. Each valid is a single-cycle pulse.
- Same-cycle wr addr 7 = 0xCAFEF00D (old 0x0) with rd0 addr 7:
  - Macro defined -> rd0_data=0xCAFEF00D.
  - Macro undefined -> 0x00000000, then 0xCAFEF00D on the next read.
- With DEPTH=20 and ADDR_WIDTH=5: write 0x5 to addr 25 and read addr 25 -> rd0_data=0, rd0_valid=1. Entries 0..19 are unchanged.
- Pulse init_req after loading data, and assert rst at clear cycle 10 of 32:
  - busy stays high and reads issued in this window produce no valid.
  - After rst release, busy is high for a further 32 cycles.
  - All entries then read 0.

Source files
------------

// File: rtl/register_file_2r1w.sv
// Two-read / one-write register file with byte-enabled writes and a hardware clear sequencer.
// Define REGFILE_WRITE_BYPASS_EN for write-first same-address reads; otherwise reads are read-first.
module register_file_2r1w #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      init_req,
  output logic                      busy,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
  input  logic                      rd0_en,
  input  logic [ADDR_WIDTH-1:0]     rd0_addr,
  output logic [DATA_WIDTH-1:0]     rd0_data,
  output logic                      rd0_valid,
  input  logic                      rd1_en,
  input  logic [ADDR_WIDTH-1:0]     rd1_addr,
  output logic [DATA_WIDTH-1:0]     rd1_data,
  output logic                      rd1_valid
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    idle;
  logic                    wr_hit;
  logic                    rd0_in_range;
  logic                    rd1_in_range;
  logic [DATA_WIDTH-1:0]   wr_merged;
  logic [DATA_WIDTH-1:0]   rd0_word;
  logic [DATA_WIDTH-1:0]   rd1_word;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_WIDTH-1:0]   be
  );
    logic [DATA_WIDTH-1:0] result;
    result = old_word;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (be[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

  assign idle         = (state == IDLE);
  assign wr_hit       = idle && wr_en && ({1'b0, wr_addr} < DEPTH_W);
  assign rd0_in_range = ({1'b0, rd0_addr} < DEPTH_W);
  assign rd1_in_range = ({1'b0, rd1_addr} < DEPTH_W);
  assign wr_merged    = merge_bytes(mem[wr_addr[IDX_WIDTH-1:0]], wr_data, wr_be);

`ifdef REGFILE_WRITE_BYPASS_EN
  assign rd0_word = !rd0_in_range ? '0 :
                    (wr_hit && (wr_addr == rd0_addr)) ? wr_merged : mem[rd0_addr[IDX_WIDTH-1:0]];
  assign rd1_word = !rd1_in_range ? '0 :
                    (wr_hit && (wr_addr == rd1_addr)) ? wr_merged : mem[rd1_addr[IDX_WIDTH-1:0]];
`else
  assign rd0_word = rd0_in_range ? mem[rd0_addr[IDX_WIDTH-1:0]] : '0;
  assign rd1_word = rd1_in_range ? mem[rd1_addr[IDX_WIDTH-1:0]] : '0;
`endif

  // Clear sequencer: one entry per cycle, busy registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST_IDX) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (init_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          clr_cnt <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: the storage array has no reset; the clear sequencer initialises it synchronously.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt[IDX_WIDTH-1:0]] <= '0;
    end else if (wr_hit) begin
      mem[wr_addr[IDX_WIDTH-1:0]] <= wr_merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd0_data  <= '0;
      rd0_valid <= 1'b0;
      rd1_data  <= '0;
      rd1_valid <= 1'b0;
    end else begin
      rd0_valid <= idle && rd0_en;
      rd1_valid <= idle && rd1_en;
      if (idle && rd0_en) rd0_data <= rd0_word;
      if (idle && rd1_en) rd1_data <= rd1_word;
    end
  end

endmodule
